// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer around instruction_decoder; owns pc and retire/invalid counters.
// Latency: valid instruction 4 cycles + fetch wait cycles; rejected instruction 2 cycles + fetch wait cycles.
// Backpressure: stalls in FETCH with imemReq high and imemAddr stable until imemValid; enable only gates instruction starts.
module instruction_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] PC_STEP         = 32'd4,
  parameter bit          HALT_ON_INVALID = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  input  logic        isVI,
  input  logic        enRegWriteDec,
  output logic        regReadEn,
  output logic        aluStart,
  output logic        regWriteEn,
  output logic        illegal,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic [31:0] retiredCount,
  output logic [15:0] invalidCount
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } stateT;

  stateT curState;
  logic  rdNonZero;

  // Destination x0 is never written, whatever the decoder says.
  assign rdNonZero = (instruction[11:7] != 5'd0);
  assign state     = curState;
  assign imemAddr  = pc;

  // Sequencer: every strobe is registered alongside the state it belongs to,
  // so outputs never depend combinationally on imemValid.
  always_ff @(posedge clk) begin
    if (rst) begin
      curState     <= IDLE;
      pc           <= RESET_PC;
      instruction  <= 32'd0;
      retiredCount <= 32'd0;
      invalidCount <= 16'd0;
      imemReq      <= 1'b0;
      regReadEn    <= 1'b0;
      aluStart     <= 1'b0;
      regWriteEn   <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      imemReq    <= 1'b0;
      regReadEn  <= 1'b0;
      aluStart   <= 1'b0;
      regWriteEn <= 1'b0;
      illegal    <= 1'b0;
      case (curState)
        IDLE: begin
          if (enable) begin
            curState <= FETCH;
            imemReq  <= 1'b1;
          end
        end
        FETCH: begin
          if (imemValid) begin
            instruction <= imemData;
            curState    <= DECODE;
            regReadEn   <= 1'b1;
          end else begin
            imemReq <= 1'b1;
          end
        end
        DECODE: begin
          if (isVI) begin
            curState <= EXECUTE;
            aluStart <= 1'b1;
          end else begin
            // Rejected word: skip it, count it, and pulse illegal with the counter update.
            illegal <= 1'b1;
            pc      <= pc + PC_STEP;
            if (invalidCount != 16'hFFFF) begin
              invalidCount <= invalidCount + 16'd1;
            end
            if (HALT_ON_INVALID) begin
              curState <= HALT;
            end else if (enable) begin
              curState <= FETCH;
              imemReq  <= 1'b1;
            end else begin
              curState <= IDLE;
            end
          end
        end
        EXECUTE: begin
          // Decoder flags are stable here (instruction register unchanged since FETCH).
          curState   <= WRITEBACK;
          regWriteEn <= enRegWriteDec && rdNonZero;
        end
        WRITEBACK: begin
          pc           <= pc + PC_STEP;
          retiredCount <= retiredCount + 32'd1;
          if (enable) begin
            curState <= FETCH;
            imemReq  <= 1'b1;
          end else begin
            curState <= IDLE;
          end
        end
        HALT: begin
          curState <= HALT;
        end
        default: begin
          curState <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer with a transaction-level reference model.
// Latency: checks per-instruction cycle counts and post-instruction architectural state.
// Backpressure: exercises fetch stalls, enable drops, halt-on-invalid and reset during a stall.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = 32'd0;

  // Main instance (defaults)
  logic        imemReq, regReadEn, aluStart, regWriteEn, illegal, isVI, enRegWriteDec;
  logic [31:0] imemAddr, instruction, pc, retiredCount;
  logic [2:0]  state;
  logic [15:0] invalidCount;

  // Halting instance with a wrap-around reset pc
  logic        imemReqH, regReadEnH, aluStartH, regWriteEnH, illegalH, isVIH, enRegWriteDecH;
  logic [31:0] imemAddrH, instructionH, pcH, retiredCountH;
  logic [2:0]  stateH;
  logic [15:0] invalidCountH;

  int checks = 0;
  int errors = 0;

  logic [31:0] expPc = 32'd0;
  logic [31:0] expRet = 32'd0;
  logic [15:0] expInv = 16'd0;
  logic [31:0] expPcH = 32'hFFFF_FFFC;
  bit          haltWatch = 1'b0;
  int          haltViol = 0;

  always #5 clk = ~clk;

  // Stand-in decoder: R-type opcode is valid; bit 31 suppresses write enable.
  assign isVI           = (instruction[6:0] == 7'h33);
  assign enRegWriteDec  = isVI & ~instruction[31];
  assign isVIH          = (instructionH[6:0] == 7'h33);
  assign enRegWriteDecH = isVIH & ~instructionH[31];

  instruction_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid), .imemData(imemData),
    .instruction(instruction), .isVI(isVI), .enRegWriteDec(enRegWriteDec),
    .regReadEn(regReadEn), .aluStart(aluStart), .regWriteEn(regWriteEn), .illegal(illegal),
    .pc(pc), .state(state), .retiredCount(retiredCount), .invalidCount(invalidCount)
  );

  instruction_sequencer #(
    .RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4), .HALT_ON_INVALID(1'b1)
  ) dutH (
    .clk(clk), .rst(rst), .enable(enable),
    .imemReq(imemReqH), .imemAddr(imemAddrH), .imemValid(imemValid), .imemData(imemData),
    .instruction(instructionH), .isVI(isVIH), .enRegWriteDec(enRegWriteDecH),
    .regReadEn(regReadEnH), .aluStart(aluStartH), .regWriteEn(regWriteEnH), .illegal(illegalH),
    .pc(pcH), .state(stateH), .retiredCount(retiredCountH), .invalidCount(invalidCountH)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (haltWatch && (stateH !== 3'd5 || imemReqH !== 1'b0 || pcH !== expPcH)) haltViol++;
  endtask

  // Run one instruction starting from a FETCH sample; waits = cycles imemValid stays low.
  task automatic runInstr(input logic [31:0] word, input int waits, input bit dropEn);
    bit valid;
    bit expWr;
    int n;
    int stateErr, reqCnt, rdCnt, aluCnt, wrCnt, wrOut, illCnt, addrErr, instrErr;
    logic [31:0] prevInstr;
    logic [2:0] expSt;
    valid = (word[6:0] == 7'h33);
    expWr = valid && !word[31] && (word[11:7] != 5'd0);
    n = waits + (valid ? 4 : 2);
    stateErr = 0; reqCnt = 0; rdCnt = 0; aluCnt = 0; wrCnt = 0; wrOut = 0;
    illCnt = 0; addrErr = 0; instrErr = 0;
    prevInstr = instruction;
    checkVal("start_fetch", {29'd0, state}, 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k <= waits) expSt = 3'd1;
      else if (k == waits + 1) expSt = 3'd2;
      else if (k == waits + 2) expSt = 3'd3;
      else expSt = 3'd4;
      if (state !== expSt) stateErr++;
      if (k > 0 && illegal) illCnt++;
      if (imemReq) reqCnt++;
      if (regReadEn) rdCnt++;
      if (aluStart) aluCnt++;
      if (regWriteEn) wrCnt++;
      if (regWriteEn && state !== 3'd4) wrOut++;
      if (k <= waits) begin
        if (imemAddr !== expPc) addrErr++;
        if (instruction !== prevInstr) instrErr++;
      end
      if (k < waits) begin
        imemValid = 1'b0;
        imemData  = $urandom;
      end else if (k == waits) begin
        imemValid = 1'b1;
        imemData  = word;
      end else begin
        imemValid = 1'($urandom);
        imemData  = $urandom;
      end
      if (dropEn && valid && k == waits + 2) enable = 1'b0;
      step();
    end
    if (illegal) illCnt++;
    expPc = expPc + 32'd4;
    if (!haltWatch) expPcH = expPcH + 32'd4;
    if (valid) expRet = expRet + 32'd1;
    else if (expInv != 16'hFFFF) expInv = expInv + 16'd1;
    checkVal("state_seq_errs", stateErr, 0);
    checkVal("imemReq_cycles", reqCnt, waits + 1);
    checkVal("fetch_addr_errs", addrErr, 0);
    checkVal("stall_instr_errs", instrErr, 0);
    checkVal("regReadEn_cnt", rdCnt, 1);
    checkVal("aluStart_cnt", aluCnt, valid ? 1 : 0);
    checkVal("regWriteEn_cnt", wrCnt, expWr ? 1 : 0);
    checkVal("regWriteEn_outside_wb", wrOut, 0);
    checkVal("illegal_cnt", illCnt, valid ? 0 : 1);
    checkVal("instr_reg", instruction, word);
    checkVal("pc_after", pc, expPc);
    checkVal("retired", retiredCount, expRet);
    checkVal("invalid", {16'd0, invalidCount}, {16'd0, expInv});
    checkVal("post_state", {29'd0, state}, enable ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int idleErr;
    int waits;
    bit drop;

    // Reset
    step();
    step();
    checkVal("rst_state", {29'd0, state}, 32'd0);
    checkVal("rst_pc", pc, 32'd0);
    checkVal("rst_instr", instruction, 32'd0);
    checkVal("rst_retired", retiredCount, 32'd0);
    checkVal("rst_invalid", {16'd0, invalidCount}, 32'd0);
    checkVal("rst_strobes", {27'd0, imemReq, regReadEn, aluStart, regWriteEn, illegal}, 32'd0);
    checkVal("rst_pcH", pcH, 32'hFFFF_FFFC);
    rst = 1'b0;
    enable = 1'b1;
    step();

    // ADD x1,x0,x0, zero wait; halting instance wraps its pc to 0
    runInstr(32'h0000_00B3, 0, 1'b0);
    checkVal("wrap_pcH", pcH, 32'd0);
    // Same instruction with a 3-cycle fetch stall
    runInstr(32'h0000_00B3, 3, 1'b0);
    // Rejected word; the halting instance parks
    runInstr(32'h0000_0093, 0, 1'b0);
    checkVal("halt_state", {29'd0, stateH}, 32'd5);
    checkVal("halt_invalid", {16'd0, invalidCountH}, 32'd1);
    checkVal("halt_pc", pcH, expPcH);
    haltWatch = 1'b1;
    // rd = x0 with write enable: no register write, still retires
    runInstr(32'h0000_0033, 0, 1'b0);
    // Drop enable during EXECUTE
    runInstr(32'h0000_00B3, 0, 1'b1);
    idleErr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (imemReq !== 1'b0 || state !== 3'd0 || pc !== expPc) idleErr++;
    end
    checkVal("idle_after_drop", idleErr, 0);
    enable = 1'b1;
    step();

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if ($urandom_range(0, 2) != 0) w[6:0] = 7'h33;
      else if (w[6:0] == 7'h33) w[0] = 1'b0;
      waits = $urandom_range(0, 3);
      drop = ($urandom_range(0, 5) == 0);
      runInstr(w, waits, drop);
      if (state == 3'd0) begin
        idleErr = 0;
        for (int j = 0; j < 2; j++) begin
          step();
          if (imemReq !== 1'b0 || state !== 3'd0) idleErr++;
        end
        checkVal("rand_idle", idleErr, 0);
        enable = 1'b1;
        step();
      end
    end
    checkVal("halt_frozen_viol", haltViol, 0);
    checkVal("halt_retired", retiredCountH, 32'd2);
    haltWatch = 1'b0;

    // Reset during a fetch stall
    imemValid = 1'b0;
    step();
    step();
    checkVal("stall_before_rst", {29'd0, state}, 32'd1);
    rst = 1'b1;
    step();
    checkVal("rst2_state", {29'd0, state}, 32'd0);
    checkVal("rst2_pc", pc, 32'd0);
    checkVal("rst2_retired", retiredCount, 32'd0);
    checkVal("rst2_invalid", {16'd0, invalidCount}, 32'd0);
    checkVal("rst2_strobes", {27'd0, imemReq, regReadEn, aluStart, regWriteEn, illegal}, 32'd0);
    checkVal("rst2_stateH", {29'd0, stateH}, 32'd0);
    checkVal("rst2_pcH", pcH, 32'hFFFF_FFFC);
    // Late imemValid in IDLE is ignored
    rst = 1'b0;
    enable = 1'b0;
    imemValid = 1'b1;
    imemData = 32'h0000_00B3;
    step();
    step();
    checkVal("late_valid_state", {29'd0, state}, 32'd0);
    checkVal("late_valid_instr", instruction, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
